vector_alu_sequencer: RTL and testbench
=======================================

// Module: vector_alu_sequencer
// PURPOSE
//  Upstream stage of the scalar FP ALU. Accepts one vector op (NUM_ELEM packed 32-bit
//  element pairs) over a valid/ready handshake. Issues the pairs to the ALU one element
//  at a time on alu_in1/alu_in2/alu_control and waits the fixed per-op pipeline latency.
//  Captures each alu_result and returns the packed result vector plus a per-element
//  zero mask over a second valid/ready handshake.
// PARAMETERS
//  NUM_ELEM  4  elements per vector (>=1); index width = $clog2(NUM_ELEM), min 1
//  MUL_LAT   4  cycles from operand presentation to a valid fpmul result (>=1)
//  ADD_LAT   3  cycles from operand presentation to a valid fpadd result (>=1)
// PORTS
//  clk            in   1            system clock, rising edge
//  rst            in   1            asynchronous, active-low reset
//  op_valid       in   1            upstream op offered
//  op_ready       out  1            sequencer can accept an op
//  op_code        in   4            4'b0010 MUL, 4'b0100 ADD; any other value is illegal
//  vec_a, vec_b   in   32*NUM_ELEM  operand vectors; element k = bits [32k+31:32k]
//  alu_in1/2      out  32           element operands to the ALU
//  alu_control    out  4            op to the ALU; 4'b0000 when no element is in flight
//  alu_result     in   32           ALU result, sampled only on capture edges
//  res_valid      out  1            result vector available
//  res_ready      in   1            downstream accepts the result
//  res_vec        out  32*NUM_ELEM  packed results, same element layout as vec_a
//  res_zero_mask  out  NUM_ELEM     bit k = (result k == 32'h0)
//  err_illegal    out  1            one-cycle pulse: illegal op_code accepted and dropped
// BEHAVIOUR
//  Reset (rst=0, asynchronous):
//   - state=IDLE, op_ready=0, all other outputs 0, element index 0, counter 0.
//   - Applies immediately from any state; an in-flight op is discarded, no result issued.
//  States:
//   - IDLE: op_ready=1. On op_valid&op_ready, latch vec_a, vec_b, op_code.
//     Legal op -> RUN; illegal op -> err_illegal=1 for the next cycle, stay in IDLE.
//   - RUN: alu_in1/alu_in2 = element[idx] of the latched vectors; alu_control = latched op.
//     LAT = MUL_LAT or ADD_LAT per the latched op; counter counts down from LAT-1.
//     When counter==0: res_vec[idx]<=alu_result and res_zero_mask[idx]<=(alu_result==0).
//     Then idx==NUM_ELEM-1 -> DONE; otherwise idx++, reload counter, present next element.
//   - DONE: alu_control=0, res_valid=1, res_vec/res_zero_mask held stable.
//     On res_ready -> IDLE, res_valid drops the next cycle.
//  Timing (edge 0 = acceptance edge):
//   - Element k operands are valid after edge k*LAT; captured at edge (k+1)*LAT.
//   - res_valid is high after edge NUM_ELEM*LAT. No inter-element gap cycle.
//  Rules:
//   - op_ready=0 in RUN and DONE; no overlap between ops, so back-to-back ops cost one IDLE cycle.
//   - op_valid in RUN/DONE is ignored and upstream must hold the op. Latched operands do
//     not follow input changes after acceptance.
//   - res_ready asserted outside DONE has no effect.
//   - res_vec clears to 0 on acceptance of a new legal op, not at DONE exit.
//   - Conv op (4'b1000) is outside this block's scope and is treated as illegal.
// STRUCTURE
//  - Shared package vp_alu_pkg: OP_MUL=4'b0010, OP_ADD=4'b0100, OP_CONV=4'b1000,
//    DATA_W=32, state encoding {IDLE,RUN,DONE}. The ALU uses the same opcode constants.
//  - No sub-module: FSM, index and latency counter sit inline.
// TESTING
//  - Reset: hold rst=0 for 3 cycles -> op_ready=0, res_valid=0, alu_control=0; op_ready=1 the
//    first cycle after release.
//  - ADD, NUM_ELEM=4, ADD_LAT=3, ALU model returns a+b after 3 cycles -> res_valid after edge 12;
//    res_vec = elementwise sums; zero_mask = 4'b0100 when element 2 sums to 0.
//  - MUL with res_ready held low 5 cycles -> res_vec stable, op_ready=0 throughout; a new
//    op_valid is not accepted until after the res_ready handshake.
//  - Illegal op_code 4'b0001 -> err_illegal pulses exactly one cycle, alu_control stays 0,
//    no res_valid, next legal op is accepted.
//  - Reset asserted mid-RUN after element 1 -> outputs zero immediately; after release a new
//    ADD completes with correct results.
//  - Back-to-back MUL then ADD -> per-op latency honoured (4 then 3 cycles per element),
//    alu_control switches 0010 -> 0000 -> 0100.

Source files
------------

// File: rtl/vp_alu_pkg.sv
// Shared definitions for the vector sequencer and the scalar FP ALU it feeds.
// The opcode values must stay in step with the ALU's own decoder.
package vp_alu_pkg;

    localparam int DATA_W = 32;

    localparam logic [3:0] OP_NONE = 4'b0000;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_ADD  = 4'b0100;
    localparam logic [3:0] OP_CONV = 4'b1000;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Only MUL and ADD are sequenced here; conversion is handled elsewhere
    function automatic logic is_legal_op(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_ADD);
    endfunction

endpackage

// File: rtl/vector_alu_sequencer_if.sv
// Op-in and result-out handshake channels of the vector ALU sequencer.
// The master side offers ops and consumes results; the slave side is the sequencer.
interface vector_alu_sequencer_if #(
    parameter int NUM_ELEM = 4
);
    import vp_alu_pkg::*;

    logic                       op_valid;
    logic                       op_ready;
    logic [3:0]                 op_code;
    logic [DATA_W*NUM_ELEM-1:0] vec_a;
    logic [DATA_W*NUM_ELEM-1:0] vec_b;
    logic                       res_valid;
    logic                       res_ready;
    logic [DATA_W*NUM_ELEM-1:0] res_vec;
    logic [NUM_ELEM-1:0]        res_zero_mask;
    logic                       err_illegal;

    modport master (
        output op_valid, op_code, vec_a, vec_b, res_ready,
        input  op_ready, res_valid, res_vec, res_zero_mask, err_illegal
    );

    modport slave (
        input  op_valid, op_code, vec_a, vec_b, res_ready,
        output op_ready, res_valid, res_vec, res_zero_mask, err_illegal
    );

endinterface

// File: rtl/vector_alu_sequencer.sv
// Streams one vector op through the scalar ALU an element at a time, waiting the
// fixed per-op pipeline latency, and hands back the packed results with a zero mask.
module vector_alu_sequencer
    import vp_alu_pkg::*;
#(
    parameter int NUM_ELEM = 4,
    parameter int MUL_LAT  = 4,
    parameter int ADD_LAT  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    vector_alu_sequencer_if.slave bus,
    output logic [DATA_W-1:0]    alu_in1,
    output logic [DATA_W-1:0]    alu_in2,
    output logic [3:0]           alu_control,
    input  logic [DATA_W-1:0]    alu_result
);

    localparam int IDX_W   = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;
    localparam int MAX_LAT = (MUL_LAT > ADD_LAT) ? MUL_LAT : ADD_LAT;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam int VEC_W   = DATA_W * NUM_ELEM;

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_ELEM - 1);
    localparam logic [CNT_W-1:0] MUL_RELOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] ADD_RELOAD = CNT_W'(ADD_LAT - 1);

    state_t           state;
    logic [VEC_W-1:0] a_lat;
    logic [VEC_W-1:0] b_lat;
    logic [3:0]       op_lat;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] next_idx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] reload;

    assign next_idx = idx + IDX_W'(1);
    assign reload   = (op_lat == OP_MUL) ? MUL_RELOAD : ADD_RELOAD;

    // The counter expiring marks the edge on which the ALU result for idx is valid
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= IDLE;
            bus.op_ready      <= 1'b0;
            bus.res_valid     <= 1'b0;
            bus.res_vec       <= '0;
            bus.res_zero_mask <= '0;
            bus.err_illegal   <= 1'b0;
            alu_in1           <= '0;
            alu_in2           <= '0;
            alu_control       <= OP_NONE;
            a_lat             <= '0;
            b_lat             <= '0;
            op_lat            <= OP_NONE;
            idx               <= '0;
            cnt               <= '0;
        end else begin
            bus.err_illegal <= 1'b0;
            case (state)
                IDLE: begin
                    bus.op_ready <= 1'b1;
                    if (bus.op_valid && bus.op_ready) begin
                        if (is_legal_op(bus.op_code)) begin
                            a_lat             <= bus.vec_a;
                            b_lat             <= bus.vec_b;
                            op_lat            <= bus.op_code;
                            idx               <= '0;
                            cnt               <= (bus.op_code == OP_MUL) ? MUL_RELOAD : ADD_RELOAD;
                            alu_in1           <= bus.vec_a[DATA_W-1:0];
                            alu_in2           <= bus.vec_b[DATA_W-1:0];
                            alu_control       <= bus.op_code;
                            bus.res_vec       <= '0;
                            bus.res_zero_mask <= '0;
                            bus.op_ready      <= 1'b0;
                            state             <= RUN;
                        end else begin
                            bus.err_illegal <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (cnt == '0) begin
                        bus.res_vec[idx*DATA_W +: DATA_W] <= alu_result;
                        bus.res_zero_mask[idx]            <= (alu_result == '0);
                        if (idx == LAST_IDX) begin
                            alu_in1       <= '0;
                            alu_in2       <= '0;
                            alu_control   <= OP_NONE;
                            bus.res_valid <= 1'b1;
                            state         <= DONE;
                        end else begin
                            idx     <= next_idx;
                            cnt     <= reload;
                            alu_in1 <= a_lat[next_idx*DATA_W +: DATA_W];
                            alu_in2 <= b_lat[next_idx*DATA_W +: DATA_W];
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DONE: begin
                    // Results stay on the bus until a new legal op is accepted
                    if (bus.res_ready) begin
                        bus.res_valid <= 1'b0;
                        bus.op_ready  <= 1'b1;
                        idx           <= '0;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vector_alu_sequencer.sv
// Self-checking bench for vector_alu_sequencer with a latency-exact ALU model.
// Expected results come from plain elementwise arithmetic on the offered vectors.
module tb_vector_alu_sequencer;
    import vp_alu_pkg::*;

    localparam int NE      = 4;
    localparam int MUL_LAT = 4;
    localparam int ADD_LAT = 3;
    localparam int VEC_W   = DATA_W * NE;

    logic              clk;
    logic              rst;
    logic [DATA_W-1:0] alu_in1;
    logic [DATA_W-1:0] alu_in2;
    logic [3:0]        alu_control;
    logic [DATA_W-1:0] alu_result;

    vector_alu_sequencer_if #(.NUM_ELEM(NE)) bus ();

    vector_alu_sequencer #(
        .NUM_ELEM (NE),
        .MUL_LAT  (MUL_LAT),
        .ADD_LAT  (ADD_LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .alu_in1     (alu_in1),
        .alu_in2     (alu_in2),
        .alu_control (alu_control),
        .alu_result  (alu_result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ALU model: a result only becomes visible exactly LAT edges after its operands
    logic [DATA_W-1:0] mul_pipe [MUL_LAT-1];
    logic [DATA_W-1:0] add_pipe [ADD_LAT-1];

    always @(posedge clk) begin
        mul_pipe[0] <= alu_in1 * alu_in2;
        add_pipe[0] <= alu_in1 + alu_in2;
        for (int i = 1; i < MUL_LAT - 1; i++) mul_pipe[i] <= mul_pipe[i-1];
        for (int i = 1; i < ADD_LAT - 1; i++) add_pipe[i] <= add_pipe[i-1];
    end

    assign alu_result = (alu_control == OP_MUL) ? mul_pipe[MUL_LAT-2] : add_pipe[ADD_LAT-2];

    typedef struct {
        logic [3:0]       op;
        logic [VEC_W-1:0] a;
        logic [VEC_W-1:0] b;
        logic [VEC_W-1:0] exp_vec;
        logic [NE-1:0]    exp_mask;
        int               hold;
    } vec_rec_t;

    vec_rec_t         table_q [4];
    int               errors = 0;
    int               checks = 0;
    logic [3:0]       cur_op;
    logic [VEC_W-1:0] cur_a;
    logic [VEC_W-1:0] cur_b;

    task automatic checkOutput(input string name, input logic [VEC_W-1:0] actual,
                               input logic [VEC_W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int opLat(input logic [3:0] op);
        return (op == OP_MUL) ? MUL_LAT : ADD_LAT;
    endfunction

    function automatic logic [VEC_W-1:0] refVec(input logic [3:0] op, input logic [VEC_W-1:0] a,
                                                input logic [VEC_W-1:0] b);
        logic [VEC_W-1:0]  r;
        logic [DATA_W-1:0] x;
        logic [DATA_W-1:0] y;
        r = '0;
        for (int k = 0; k < NE; k++) begin
            x = a[DATA_W*k +: DATA_W];
            y = b[DATA_W*k +: DATA_W];
            r[DATA_W*k +: DATA_W] = (op == OP_MUL) ? x * y : x + y;
        end
        return r;
    endfunction

    function automatic logic [NE-1:0] refMask(input logic [VEC_W-1:0] r);
        logic [NE-1:0] m;
        for (int k = 0; k < NE; k++) m[k] = (r[DATA_W*k +: DATA_W] == '0);
        return m;
    endfunction

    // Offer an op at a negedge, wait (bounded) for acceptance, then scramble the inputs
    task automatic startOp(input logic [3:0] op, input logic [VEC_W-1:0] a, input logic [VEC_W-1:0] b);
        int n;
        cur_op       = op;
        cur_a        = a;
        cur_b        = b;
        bus.op_valid = 1'b1;
        bus.op_code  = op;
        bus.vec_a    = a;
        bus.vec_b    = b;
        n = 0;
        while (bus.op_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("op_ready_before_accept", VEC_W'(bus.op_ready), VEC_W'(1));
        checkOutput("idle_alu_control", VEC_W'(alu_control), VEC_W'(OP_NONE));
        @(posedge clk);
        @(negedge clk);
        bus.op_valid = 1'b0;
        bus.op_code  = 4'($urandom);
        bus.vec_a    = ~a;
        bus.vec_b    = {b[VEC_W/2-1:0], b[VEC_W-1:VEC_W/2]};
    endtask

    task automatic traceOp(input logic [VEC_W-1:0] exp_vec, input logic [NE-1:0] exp_mask);
        int lat;
        int k;
        lat = opLat(cur_op);
        checkOutput("res_vec_cleared", bus.res_vec, '0);
        for (int j = 0; j < NE * lat; j++) begin
            k = j / lat;
            checkOutput("run_res_valid", VEC_W'(bus.res_valid), VEC_W'(0));
            checkOutput("run_op_ready", VEC_W'(bus.op_ready), VEC_W'(0));
            checkOutput("run_alu_control", VEC_W'(alu_control), VEC_W'(cur_op));
            checkOutput("run_alu_in1", VEC_W'(alu_in1), VEC_W'(cur_a[DATA_W*k +: DATA_W]));
            checkOutput("run_alu_in2", VEC_W'(alu_in2), VEC_W'(cur_b[DATA_W*k +: DATA_W]));
            bus.res_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        bus.res_ready = 1'b0;
        checkOutput("done_res_valid", VEC_W'(bus.res_valid), VEC_W'(1));
        checkOutput("done_res_vec", bus.res_vec, exp_vec);
        checkOutput("done_zero_mask", VEC_W'(bus.res_zero_mask), VEC_W'(exp_mask));
        checkOutput("done_alu_control", VEC_W'(alu_control), VEC_W'(OP_NONE));
        checkOutput("done_err_illegal", VEC_W'(bus.err_illegal), VEC_W'(0));
    endtask

    task automatic finishOp(input logic [VEC_W-1:0] exp_vec, input logic [NE-1:0] exp_mask,
                            input int hold, input bit pend);
        for (int i = 0; i < hold; i++) begin
            if (pend) begin
                bus.op_valid = 1'b1;
                bus.op_code  = OP_ADD;
                bus.vec_a    = {4{32'($urandom)}};
                bus.vec_b    = {4{32'($urandom)}};
            end
            @(negedge clk);
            checkOutput("hold_res_valid", VEC_W'(bus.res_valid), VEC_W'(1));
            checkOutput("hold_res_vec", bus.res_vec, exp_vec);
            checkOutput("hold_op_ready", VEC_W'(bus.op_ready), VEC_W'(0));
            checkOutput("hold_alu_control", VEC_W'(alu_control), VEC_W'(OP_NONE));
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        checkOutput("exit_res_valid", VEC_W'(bus.res_valid), VEC_W'(0));
        checkOutput("exit_op_ready", VEC_W'(bus.op_ready), VEC_W'(1));
        checkOutput("exit_res_vec_held", bus.res_vec, exp_vec);
        checkOutput("exit_zero_mask_held", VEC_W'(bus.res_zero_mask), VEC_W'(exp_mask));
        checkOutput("exit_alu_control", VEC_W'(alu_control), VEC_W'(OP_NONE));
    endtask

    task automatic applyStimulus(input logic [3:0] op, input logic [VEC_W-1:0] a,
                                 input logic [VEC_W-1:0] b, input logic [VEC_W-1:0] exp_vec,
                                 input logic [NE-1:0] exp_mask, input int hold);
        startOp(op, a, b);
        traceOp(exp_vec, exp_mask);
        finishOp(exp_vec, exp_mask, hold, 1'b0);
    endtask

    task automatic illegalOp(input logic [3:0] code);
        bus.op_valid = 1'b1;
        bus.op_code  = code;
        bus.vec_a    = {4{32'hDEAD_BEEF}};
        bus.vec_b    = {4{32'h1234_5678}};
        @(negedge clk);
        bus.op_valid = 1'b0;
        checkOutput("illegal_err_pulse", VEC_W'(bus.err_illegal), VEC_W'(1));
        checkOutput("illegal_alu_control", VEC_W'(alu_control), VEC_W'(OP_NONE));
        checkOutput("illegal_op_ready", VEC_W'(bus.op_ready), VEC_W'(1));
        @(negedge clk);
        checkOutput("illegal_err_drop", VEC_W'(bus.err_illegal), VEC_W'(0));
        repeat (2) begin
            @(negedge clk);
            checkOutput("illegal_no_result", VEC_W'(bus.res_valid), VEC_W'(0));
            checkOutput("illegal_alu_idle", VEC_W'(alu_control), VEC_W'(OP_NONE));
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation timed out");
    end

    initial begin
        logic [VEC_W-1:0]  ra;
        logic [VEC_W-1:0]  rb;
        logic [VEC_W-1:0]  rexp;
        logic [DATA_W-1:0] x;
        logic [DATA_W-1:0] y;
        logic [3:0]        rop;

        table_q[0] = '{op: OP_ADD,
                       a: {32'd4, 32'd5, 32'd6, 32'd7},
                       b: {32'd10, 32'hFFFF_FFFB, 32'd1, 32'd2},
                       exp_vec: {32'd14, 32'd0, 32'd7, 32'd9},
                       exp_mask: 4'b0100, hold: 0};
        table_q[1] = '{op: OP_MUL,
                       a: {32'd3, 32'd0, 32'd100, 32'h0001_0000},
                       b: {32'd7, 32'd55, 32'd100, 32'h0001_0000},
                       exp_vec: {32'd21, 32'd0, 32'd10000, 32'd0},
                       exp_mask: 4'b0101, hold: 2};
        table_q[2] = '{op: OP_ADD, a: '0, b: '0, exp_vec: '0, exp_mask: 4'b1111, hold: 1};
        table_q[3] = '{op: OP_MUL,
                       a: {32'd2, 32'd2, 32'd2, 32'd2},
                       b: {32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 32'd0},
                       exp_vec: {32'd0, 32'd2, 32'hFFFF_FFFE, 32'd0},
                       exp_mask: 4'b1001, hold: 0};

        rst           = 1'b0;
        bus.op_valid  = 1'b0;
        bus.op_code   = 4'b0000;
        bus.vec_a     = '0;
        bus.vec_b     = '0;
        bus.res_ready = 1'b0;

        repeat (3) begin
            @(negedge clk);
            checkOutput("reset_op_ready", VEC_W'(bus.op_ready), VEC_W'(0));
            checkOutput("reset_res_valid", VEC_W'(bus.res_valid), VEC_W'(0));
            checkOutput("reset_alu_control", VEC_W'(alu_control), VEC_W'(OP_NONE));
        end
        rst = 1'b1;
        @(negedge clk);
        checkOutput("release_op_ready", VEC_W'(bus.op_ready), VEC_W'(1));

        for (int i = 0; i < 4; i++) begin
            applyStimulus(table_q[i].op, table_q[i].a, table_q[i].b,
                          table_q[i].exp_vec, table_q[i].exp_mask, table_q[i].hold);
        end

        $display("[TB] illegal opcodes");
        illegalOp(4'b0001);
        illegalOp(OP_CONV);
        applyStimulus(table_q[0].op, table_q[0].a, table_q[0].b,
                      table_q[0].exp_vec, table_q[0].exp_mask, 0);

        $display("[TB] MUL with stalled consumer and pending op");
        startOp(table_q[1].op, table_q[1].a, table_q[1].b);
        traceOp(table_q[1].exp_vec, table_q[1].exp_mask);
        finishOp(table_q[1].exp_vec, table_q[1].exp_mask, 5, 1'b1);
        applyStimulus(table_q[0].op, table_q[0].a, table_q[0].b,
                      table_q[0].exp_vec, table_q[0].exp_mask, 0);

        $display("[TB] reset mid-run");
        startOp(table_q[0].op, table_q[0].a, table_q[0].b);
        repeat (4) @(negedge clk);
        checkOutput("midrun_alu_in1_elem1", VEC_W'(alu_in1), VEC_W'(table_q[0].a[63:32]));
        rst = 1'b0;
        #1;
        checkOutput("midrun_rst_op_ready", VEC_W'(bus.op_ready), VEC_W'(0));
        checkOutput("midrun_rst_res_valid", VEC_W'(bus.res_valid), VEC_W'(0));
        checkOutput("midrun_rst_alu_control", VEC_W'(alu_control), VEC_W'(OP_NONE));
        checkOutput("midrun_rst_alu_in1", VEC_W'(alu_in1), VEC_W'(0));
        checkOutput("midrun_rst_alu_in2", VEC_W'(alu_in2), VEC_W'(0));
        checkOutput("midrun_rst_res_vec", bus.res_vec, '0);
        checkOutput("midrun_rst_zero_mask", VEC_W'(bus.res_zero_mask), VEC_W'(0));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("midrun_after_no_result", VEC_W'(bus.res_valid), VEC_W'(0));
        end
        applyStimulus(table_q[0].op, table_q[0].a, table_q[0].b,
                      table_q[0].exp_vec, table_q[0].exp_mask, 0);

        $display("[TB] back-to-back MUL then ADD");
        applyStimulus(table_q[1].op, table_q[1].a, table_q[1].b,
                      table_q[1].exp_vec, table_q[1].exp_mask, 0);
        applyStimulus(table_q[0].op, table_q[0].a, table_q[0].b,
                      table_q[0].exp_vec, table_q[0].exp_mask, 0);

        $display("[TB] randomized ops");
        for (int r = 0; r < 8; r++) begin
            rop = ($urandom_range(0, 1) == 1) ? OP_MUL : OP_ADD;
            for (int k = 0; k < NE; k++) begin
                x = $urandom;
                y = $urandom;
                if ($urandom_range(0, 3) == 0) begin
                    if (rop == OP_MUL) x = '0;
                    else y = -x;
                end
                ra[DATA_W*k +: DATA_W] = x;
                rb[DATA_W*k +: DATA_W] = y;
            end
            rexp = refVec(rop, ra, rb);
            applyStimulus(rop, ra, rb, rexp, refMask(rexp), $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
